ddr_burst_sched: RTL and testbench

- Schedules the shared DDR port between two requesters: draining the AD sample FIFO (fifo_ad) into DDR, and refilling the wavelet-filter input FIFO (fifo_xb) from DDR.
- Treats DDR as a ring buffer of 2^ADDR_W words, moved in fixed-length bursts.
- Sits inside ddr_top on the clk_150_0 domain, between the FIFOs and the DDR command/data interface.

---
 rtl/ddr_pkg.sv | 21 ++
 rtl/ddr_sched_arb.sv | 62 ++++++
 rtl/ddr_burst_sched.sv | 167 ++++++++++++++++
 tb/tb_ddr_burst_sched.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_pkg.sv
// Shared definitions for the DDR burst scheduler: FSM encoding, grant type
// and the default ring/burst geometry.
package ddr_pkg;

  localparam int ADDR_W_DEF    = 10;
  localparam int BURST_LEN_DEF = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_CMD  = 3'd1,
    WR_DATA = 3'd2,
    RD_CMD  = 3'd3,
    RD_DATA = 3'd4
  } state_t;

  typedef enum logic {
    GRANT_RD = 1'b0,
    GRANT_WR = 1'b1
  } grant_t;

endpackage

// File: rtl/ddr_sched_arb.sv
// Eligibility and priority between the fifo_ad drain (write) and the fifo_xb
// refill (read), plus the last_grant memory used to alternate fairly.
module ddr_sched_arb
  import ddr_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int USE_W     = 10,
  parameter int XB_DEPTH  = 512,
  parameter int AD_URGENT = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W:0]   level,
  input  logic [USE_W-1:0]  fifo_ad_use,
  input  logic [USE_W-1:0]  fifo_xb_use,
  input  logic              wr_done,
  input  logic              rd_done,
  output logic              grant_wr,
  output logic              grant_rd
);

  localparam int RING = 1 << ADDR_W;

  grant_t last_grant;
  logic   wr_ok;
  logic   rd_ok;
  logic   urgent;

  assign wr_ok  = (int'(fifo_ad_use) >= BURST_LEN) && (int'(level) <= RING - BURST_LEN);
  // Room test written as an addition so a use count above XB_DEPTH cannot wrap.
  assign rd_ok  = (int'(level) >= BURST_LEN) && (int'(fifo_xb_use) + BURST_LEN <= XB_DEPTH);
  assign urgent = wr_ok && (int'(fifo_ad_use) >= AD_URGENT);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (urgent) begin
      grant_wr = 1'b1;
    end else if (wr_ok && rd_ok) begin
      if (last_grant == GRANT_RD) grant_wr = 1'b1;
      else                        grant_rd = 1'b1;
    end else if (wr_ok) begin
      grant_wr = 1'b1;
    end else if (rd_ok) begin
      grant_rd = 1'b1;
    end
  end

  // NOTE: reset here is synchronous; it only takes effect on a clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= GRANT_RD;
    end else if (wr_done) begin
      last_grant <= GRANT_WR;
    end else if (rd_done) begin
      last_grant <= GRANT_RD;
    end
  end

endmodule

// File: rtl/ddr_burst_sched.sv
// Shares the DDR port between fifo_ad drain bursts and fifo_xb refill bursts,
// treating DDR as a ring buffer. Define DDR_BURST_SCHED_STATS_EN for burst counters.
module ddr_burst_sched
  import ddr_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int USE_W     = 10,
  parameter int XB_DEPTH  = 512,
  parameter int AD_URGENT = 256
) (
  input  logic              clk_150_0,
  input  logic              reset_1_150_0,
  input  logic              enable,
  input  logic [USE_W-1:0]  fifo_ad_use,
  input  logic              fifo_ad_full,
  output logic              fifo_ad_rreq,
  input  logic [USE_W-1:0]  fifo_xb_use,
  output logic              fifo_xb_wreq,
  output logic              ddr_cmd_valid,
  input  logic              ddr_cmd_ready,
  output logic              ddr_cmd_write,
  output logic [ADDR_W-1:0] ddr_addr,
  input  logic              ddr_wr_ready,
  input  logic              ddr_rd_valid,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              busy
`ifdef DDR_BURST_SCHED_STATS_EN
  ,
  output logic [15:0]       wr_burst_cnt,
  output logic [15:0]       rd_burst_cnt,
  output logic [ADDR_W:0]   max_level
`endif
);

  localparam logic [ADDR_W-1:0] PTR_STEP  = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W:0]   LVL_STEP  = (ADDR_W + 1)'(BURST_LEN);
  localparam logic [6:0]        LAST_BEAT = 7'(BURST_LEN - 1);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [6:0]        beat_cnt;
  logic              wr_beat;
  logic              rd_beat;
  logic              wr_done;
  logic              rd_done;
  logic              grant_wr;
  logic              grant_rd;

  ddr_sched_arb #(
    .ADDR_W    (ADDR_W),
    .BURST_LEN (BURST_LEN),
    .USE_W     (USE_W),
    .XB_DEPTH  (XB_DEPTH),
    .AD_URGENT (AD_URGENT)
  ) u_arb (
    .clk         (clk_150_0),
    .rst_n       (reset_1_150_0),
    .level       (level),
    .fifo_ad_use (fifo_ad_use),
    .fifo_xb_use (fifo_xb_use),
    .wr_done     (wr_done),
    .rd_done     (rd_done),
    .grant_wr    (grant_wr),
    .grant_rd    (grant_rd)
  );

  // Beat strobes are combinational so fifo_ad show-ahead data reaches DDR directly.
  assign wr_beat      = (state == WR_DATA) && ddr_wr_ready;
  assign rd_beat      = (state == RD_DATA) && ddr_rd_valid;
  assign wr_done      = wr_beat && (beat_cnt == LAST_BEAT);
  assign rd_done      = rd_beat && (beat_cnt == LAST_BEAT);
  assign fifo_ad_rreq = wr_beat;
  assign fifo_xb_wreq = rd_beat;
  assign busy         = (state != IDLE);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (enable) begin
          if      (grant_wr) state_next = WR_CMD;
          else if (grant_rd) state_next = RD_CMD;
        end
      end
      WR_CMD:  if (ddr_cmd_ready) state_next = WR_DATA;
      WR_DATA: if (wr_done)       state_next = IDLE;
      RD_CMD:  if (ddr_cmd_ready) state_next = RD_DATA;
      RD_DATA: if (rd_done)       state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk_150_0) begin
    if (!reset_1_150_0) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      beat_cnt      <= '0;
      ddr_cmd_valid <= 1'b0;
      ddr_cmd_write <= 1'b0;
      ddr_addr      <= '0;
      overflow      <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (state_next == WR_CMD) begin
            ddr_cmd_valid <= 1'b1;
            ddr_cmd_write <= 1'b1;
            ddr_addr      <= wr_ptr;
          end else if (state_next == RD_CMD) begin
            ddr_cmd_valid <= 1'b1;
            ddr_cmd_write <= 1'b0;
            ddr_addr      <= rd_ptr;
          end
        end
        WR_CMD, RD_CMD: begin
          if (ddr_cmd_ready) begin
            ddr_cmd_valid <= 1'b0;
            beat_cnt      <= '0;
          end
        end
        WR_DATA: begin
          if (wr_beat) beat_cnt <= beat_cnt + 7'd1;
          if (wr_done) begin
            wr_ptr <= wr_ptr + PTR_STEP;
            level  <= level + LVL_STEP;
          end
        end
        RD_DATA: begin
          if (rd_beat) beat_cnt <= beat_cnt + 7'd1;
          if (rd_done) begin
            rd_ptr <= rd_ptr + PTR_STEP;
            level  <= level - LVL_STEP;
          end
        end
        default: ;
      endcase
      if (fifo_ad_full && enable) overflow <= 1'b1;
    end
  end

`ifdef DDR_BURST_SCHED_STATS_EN
  always_ff @(posedge clk_150_0) begin
    if (!reset_1_150_0) begin
      wr_burst_cnt <= '0;
      rd_burst_cnt <= '0;
      max_level    <= '0;
    end else begin
      if (wr_done) begin
        wr_burst_cnt <= wr_burst_cnt + 16'd1;
        // Level only rises on write completion, so the mark is updated there.
        if (level + LVL_STEP > max_level) max_level <= level + LVL_STEP;
      end
      if (rd_done) rd_burst_cnt <= rd_burst_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ddr_burst_sched.sv
// Directed bench for ddr_burst_sched: a small DDR responder serves each
// burst while the bench steers FIFO use counts and checks grants, addresses and level.
module tb_ddr_burst_sched;

  localparam int ADDR_W    = 10;
  localparam int BURST_LEN = 8;
  localparam int USE_W     = 10;

  logic              clk_150_0 = 1'b0;
  logic              reset_1_150_0 = 1'b0;
  logic              enable = 1'b0;
  logic [USE_W-1:0]  fifo_ad_use = '0;
  logic              fifo_ad_full = 1'b0;
  logic              fifo_ad_rreq;
  logic [USE_W-1:0]  fifo_xb_use = 10'd512;
  logic              fifo_xb_wreq;
  logic              ddr_cmd_valid;
  logic              ddr_cmd_ready = 1'b0;
  logic              ddr_cmd_write;
  logic [ADDR_W-1:0] ddr_addr;
  logic              ddr_wr_ready = 1'b0;
  logic              ddr_rd_valid = 1'b0;
  logic [ADDR_W:0]   level;
  logic              overflow;
  logic              busy;
`ifdef DDR_BURST_SCHED_STATS_EN
  logic [15:0]       wr_burst_cnt;
  logic [15:0]       rd_burst_cnt;
  logic [ADDR_W:0]   max_level;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_150_0 = ~clk_150_0;

  ddr_burst_sched dut (
    .clk_150_0     (clk_150_0),
    .reset_1_150_0 (reset_1_150_0),
    .enable        (enable),
    .fifo_ad_use   (fifo_ad_use),
    .fifo_ad_full  (fifo_ad_full),
    .fifo_ad_rreq  (fifo_ad_rreq),
    .fifo_xb_use   (fifo_xb_use),
    .fifo_xb_wreq  (fifo_xb_wreq),
    .ddr_cmd_valid (ddr_cmd_valid),
    .ddr_cmd_ready (ddr_cmd_ready),
    .ddr_cmd_write (ddr_cmd_write),
    .ddr_addr      (ddr_addr),
    .ddr_wr_ready  (ddr_wr_ready),
    .ddr_rd_valid  (ddr_rd_valid),
    .level         (level),
    .overflow      (overflow),
    .busy          (busy)
`ifdef DDR_BURST_SCHED_STATS_EN
    ,
    .wr_burst_cnt  (wr_burst_cnt),
    .rd_burst_cnt  (rd_burst_cnt),
    .max_level     (max_level)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Waits for a command, accepts it after rdy_delay cycles, then streams BURST_LEN
  // beats (with gaps when gap != 0) and checks the FIFO strobe mirrors the beat.
  task automatic serve_burst(input int rdy_delay, input int gap, output logic is_wr,
                             output logic [ADDR_W-1:0] addr, output int pulses,
                             output int mirror_err);
    int  waitc = 0;
    int  beats = 0;
    int  cyc   = 0;
    logic drv;
    is_wr = 1'b0; addr = '0; pulses = 0; mirror_err = 0;
    while (ddr_cmd_valid !== 1'b1 && waitc < 200) begin
      @(negedge clk_150_0);
      waitc++;
    end
    if (ddr_cmd_valid !== 1'b1) begin
      check("cmd_timeout", 32'(ddr_cmd_valid), 32'd1);
      return;
    end
    is_wr = ddr_cmd_write;
    addr  = ddr_addr;
    for (int i = 0; i < rdy_delay; i++) begin
      @(negedge clk_150_0);
      if (ddr_cmd_valid !== 1'b1 || ddr_cmd_write !== is_wr || ddr_addr !== addr) mirror_err++;
    end
    ddr_cmd_ready = 1'b1;
    @(negedge clk_150_0);
    ddr_cmd_ready = 1'b0;
    while (beats < BURST_LEN && cyc < 100) begin
      drv = (gap == 0) ? 1'b1 : ((cyc % 3) != 1);
      if (is_wr) ddr_wr_ready = drv;
      else       ddr_rd_valid = drv;
      #1;
      if (is_wr) begin
        if (fifo_ad_rreq !== drv || fifo_xb_wreq !== 1'b0) mirror_err++;
        if (fifo_ad_rreq === 1'b1) pulses++;
      end else begin
        if (fifo_xb_wreq !== drv || fifo_ad_rreq !== 1'b0) mirror_err++;
        if (fifo_xb_wreq === 1'b1) pulses++;
      end
      if (drv) beats++;
      cyc++;
      @(negedge clk_150_0);
    end
    ddr_wr_ready = 1'b0;
    ddr_rd_valid = 1'b0;
    if (busy !== 1'b0) mirror_err++;
  endtask

  task automatic run_burst(input string tag, input logic exp_wr, input int exp_addr,
                           input int exp_level, input int rdy_delay, input int gap);
    logic              is_wr;
    logic [ADDR_W-1:0] addr;
    int                pulses;
    int                merr;
    serve_burst(rdy_delay, gap, is_wr, addr, pulses, merr);
    check({tag, "_dir"},    32'(is_wr),  32'(exp_wr));
    check({tag, "_addr"},   32'(addr),   32'(exp_addr));
    check({tag, "_pulses"}, 32'(pulses), 32'(BURST_LEN));
    check({tag, "_mirror"}, 32'(merr),   32'd0);
    check({tag, "_level"},  32'(level),  32'(exp_level));
  endtask

  task automatic no_grant(input string tag, input int cycles);
    int hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_150_0);
      if (ddr_cmd_valid !== 1'b0 || busy !== 1'b0) hits++;
    end
    check(tag, 32'(hits), 32'd0);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic              is_wr;
    logic [ADDR_W-1:0] addr;
    int                pulses;
    int                merr;
    int                fill_err;

    // Reset state
    repeat (3) @(negedge clk_150_0);
    check("rst_valid",    32'(ddr_cmd_valid), 32'd0);
    check("rst_write",    32'(ddr_cmd_write), 32'd0);
    check("rst_addr",     32'(ddr_addr),      32'd0);
    check("rst_level",    32'(level),         32'd0);
    check("rst_overflow", 32'(overflow),      32'd0);
    check("rst_busy",     32'(busy),          32'd0);
    check("rst_rreq",     32'(fifo_ad_rreq),  32'd0);
    check("rst_wreq",     32'(fifo_xb_wreq),  32'd0);
    reset_1_150_0 = 1'b1;

    // enable low: eligible write must not start
    fifo_ad_use = 10'd8;
    no_grant("disabled_no_grant", 5);
    enable = 1'b1;

    // Write path, command accepted two cycles after valid; second write proves wr_ptr = 8
    run_burst("wr0", 1'b1, 0, 8, 2, 1);
    run_burst("wr1", 1'b1, 8, 16, 0, 0);
    fifo_ad_use = 10'd0;
    fifo_xb_use = 10'd0;

    // Read path; second read proves rd_ptr = 8
    run_burst("rd0", 1'b0, 0, 8, 1, 1);
    run_burst("rd1", 1'b0, 8, 0, 0, 0);
    fifo_xb_use = 10'd512;
    fifo_ad_use = 10'd100;

    // Build level 72, then one read so last grant is read at level 64
    fill_err = 0;
    for (int i = 0; i < 9; i++) begin
      serve_burst(0, 0, is_wr, addr, pulses, merr);
      if (is_wr !== 1'b1 || addr !== ADDR_W'(16 + 8 * i) || pulses != BURST_LEN || merr != 0) fill_err++;
    end
    check("prefill_errs", 32'(fill_err), 32'd0);
    fifo_ad_use = 10'd0;
    fifo_xb_use = 10'd0;
    run_burst("rd2", 1'b0, 16, 64, 0, 0);
    fifo_ad_use = 10'd100;

    // Alternation W, R, W, R
    run_burst("alt0", 1'b1, 88, 72, 0, 1);
    run_burst("alt1", 1'b0, 24, 64, 0, 1);
    run_burst("alt2", 1'b1, 96, 72, 0, 0);
    run_burst("alt3", 1'b0, 32, 64, 0, 0);

    // Urgent: consecutive writes despite an eligible read
    fifo_ad_use = 10'd300;
    run_burst("urg0", 1'b1, 104, 72, 0, 0);
    run_burst("urg1", 1'b1, 112, 80, 0, 0);
    fifo_ad_use = 10'd0;

    // Back-pressure: room 7 blocks, room 8 allows
    fifo_xb_use = 10'd505;
    no_grant("xb_room7_no_grant", 20);
    fifo_xb_use = 10'd504;
    run_burst("xb_room8", 1'b0, 40, 72, 0, 0);
    fifo_xb_use = 10'd512;

    // Reset in WR_DATA beat 3
    fifo_ad_use = 10'd8;
    serve_burst_start: begin
      int waitc = 0;
      while (ddr_cmd_valid !== 1'b1 && waitc < 200) begin
        @(negedge clk_150_0);
        waitc++;
      end
      check("mid_cmd_write", 32'(ddr_cmd_write), 32'd1);
      check("mid_cmd_addr",  32'(ddr_addr),      32'd120);
      ddr_cmd_ready = 1'b1;
      @(negedge clk_150_0);
      ddr_cmd_ready = 1'b0;
      ddr_wr_ready  = 1'b1;
      repeat (3) @(negedge clk_150_0);
      reset_1_150_0 = 1'b0;
      @(negedge clk_150_0);
      check("mid_rst_busy",  32'(busy),          32'd0);
      check("mid_rst_valid", 32'(ddr_cmd_valid), 32'd0);
      check("mid_rst_rreq",  32'(fifo_ad_rreq),  32'd0);
      check("mid_rst_level", 32'(level),         32'd0);
      check("mid_rst_addr",  32'(ddr_addr),      32'd0);
`ifdef DDR_BURST_SCHED_STATS_EN
      check("mid_rst_wr_cnt",    32'(wr_burst_cnt), 32'd0);
      check("mid_rst_rd_cnt",    32'(rd_burst_cnt), 32'd0);
      check("mid_rst_max_level", 32'(max_level),    32'd0);
`endif
      ddr_wr_ready  = 1'b0;
      reset_1_150_0 = 1'b1;
    end

    // Fill the ring from pointer 0: 128 urgent writes, last one at 1016
    fifo_ad_use = 10'd300;
    fill_err = 0;
    addr = '0;
    for (int i = 0; i < 128; i++) begin
      serve_burst(0, 0, is_wr, addr, pulses, merr);
      if (is_wr !== 1'b1 || addr !== ADDR_W'(8 * i) || pulses != BURST_LEN || merr != 0) fill_err++;
    end
    check("fill_errs",      32'(fill_err), 32'd0);
    check("fill_last_addr", 32'(addr),     32'd1016);
    check("ring_full_level", 32'(level),   32'd1024);
    fifo_ad_use = 10'd500;
    no_grant("ring_full_no_write", 30);

    // Overflow: ignored while disabled, sticky once seen while enabled
    enable = 1'b0;
    fifo_ad_full = 1'b1;
    @(negedge clk_150_0);
    fifo_ad_full = 1'b0;
    @(negedge clk_150_0);
    check("ovf_disabled", 32'(overflow), 32'd0);
    enable = 1'b1;
    fifo_ad_full = 1'b1;
    @(negedge clk_150_0);
    fifo_ad_full = 1'b0;
    check("ovf_set", 32'(overflow), 32'd1);
    repeat (5) @(negedge clk_150_0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Drain one burst, then a write at pointer 0 proves wr_ptr wrapped
    fifo_ad_use = 10'd0;
    fifo_xb_use = 10'd0;
    run_burst("full_rd", 1'b0, 0, 1016, 0, 0);
    fifo_xb_use = 10'd512;
    fifo_ad_use = 10'd8;
    run_burst("wrap_wr", 1'b1, 0, 1024, 0, 0);
    fifo_ad_use = 10'd0;
`ifdef DDR_BURST_SCHED_STATS_EN
    check("stat_wr_cnt",    32'(wr_burst_cnt), 32'd129);
    check("stat_rd_cnt",    32'(rd_burst_cnt), 32'd1);
    check("stat_max_level", 32'(max_level),    32'd1024);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
